// File: rtl/cv32e40x_trace_fifo.sv
// Retirement-trace capture FIFO: up to NUM_PORTS events per cycle, timestamped, drained in order.
// Overflow either drops the newest events or overwrites the oldest; both are counted.
module cv32e40x_trace_fifo #(
    parameter int NUM_PORTS = 1,
    parameter int DEPTH     = 8,
    parameter int TS_W      = 16,
    parameter int CNT_W     = 16,
    parameter bit OVERWRITE = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       trace_en_i,
    input  logic                       flush_i,
    input  logic [NUM_PORTS-1:0]       ret_valid_i,
    input  logic [NUM_PORTS*32-1:0]    ret_pc_i,
    input  logic [NUM_PORTS*32-1:0]    ret_instr_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [31:0]                out_pc_o,
    output logic [31:0]                out_instr_o,
    output logic [TS_W-1:0]            out_ts_o,
    output logic                       out_drop_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [CNT_W-1:0]           drop_cnt_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [31:0]      pc_q    [DEPTH];
    logic [31:0]      pc_d    [DEPTH];
    logic [31:0]      instr_q [DEPTH];
    logic [31:0]      instr_d [DEPTH];
    logic [TS_W-1:0]  ets_q   [DEPTH];
    logic [TS_W-1:0]  ets_d   [DEPTH];
    logic [DEPTH-1:0] edrop_q, edrop_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d, slot;
    logic [LW-1:0]    level_q, level_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [CNT_W+3:0] cnt_sum;
    logic             out_valid, pop;
    int               k, free_n, n_acc, n_disc, n_ovw, idx;

    always_comb begin
        out_valid = (level_q != '0);
        pop       = out_valid && out_ready_i;

        k = 0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (trace_en_i && ret_valid_i[p]) k = k + 1;
        end
        free_n = DEPTH - int'(level_q) + (pop ? 1 : 0);

        // n_disc counts lost events in both modes; n_ovw is the part that evicts old entries
        if (OVERWRITE) begin
            n_acc  = k;
            n_disc = (k > free_n) ? (k - free_n) : 0;
            n_ovw  = n_disc;
        end else begin
            n_acc  = (k > free_n) ? free_n : k;
            n_disc = k - n_acc;
            n_ovw  = 0;
        end

        pc_d    = pc_q;
        instr_d = instr_q;
        ets_d   = ets_q;
        edrop_d = edrop_q;
        slot    = '0;
        idx     = 0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (trace_en_i && ret_valid_i[p] && (idx < n_acc)) begin
                slot          = tail_q + PW'(idx);
                pc_d[slot]    = ret_pc_i[32*p +: 32];
                instr_d[slot] = ret_instr_i[32*p +: 32];
                ets_d[slot]   = ts_q;
                edrop_d[slot] = (idx == 0) && pend_q;
                idx           = idx + 1;
            end
        end

        head_d = head_q + PW'(pop ? 1 : 0) + PW'(n_ovw);
        if (n_ovw != 0) edrop_d[head_d] = 1'b1;
        tail_d  = tail_q + PW'(n_acc);
        level_d = LW'(int'(level_q) - (pop ? 1 : 0) + n_acc - n_ovw);
        ts_d    = trace_en_i ? (ts_q + TS_W'(1)) : ts_q;

        // Dropped ports are always the youngest, so the flag lands on a later cycle's first entry
        pend_d = pend_q;
        if (!OVERWRITE) begin
            if (n_acc != 0)  pend_d = 1'b0;
            if (n_disc != 0) pend_d = 1'b1;
        end

        cnt_sum = {4'b0, cnt_q} + (CNT_W+4)'(n_disc);
        cnt_d   = (cnt_sum > {4'b0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            level_d = '0;
            ts_d    = '0;
            cnt_d   = '0;
            pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
                ets_q[i]   <= '0;
            end
            edrop_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
            ts_q    <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ets_q   <= ets_d;
            edrop_q <= edrop_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
            ts_q    <= ts_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    assign out_valid_o = out_valid;
    assign out_pc_o    = out_valid ? pc_q[head_q]    : '0;
    assign out_instr_o = out_valid ? instr_q[head_q] : '0;
    assign out_ts_o    = out_valid ? ets_q[head_q]   : '0;
    assign out_drop_o  = out_valid && edrop_q[head_q];
    assign level_o     = level_q;
    assign full_o      = (level_q == LW'(DEPTH));
    assign empty_o     = (level_q == '0);
    assign drop_cnt_o  = cnt_q;
endmodule

// File: tb/tb_cv32e40x_trace_fifo.sv
// Directed bench: two instances (drop-newest and overwrite-oldest) share one stimulus stream.
module tb_cv32e40x_trace_fifo;
    logic        clk = 1'b0;
    logic        rst, trace_en, flush, out_ready;
    logic [1:0]  ret_valid;
    logic [63:0] ret_pc, ret_instr;

    logic        a_valid, a_drop, a_full, a_empty;
    logic [31:0] a_pc, a_instr;
    logic [3:0]  a_ts;
    logic [2:0]  a_level;
    logic [1:0]  a_cnt;
    logic        b_valid, b_drop, b_full, b_empty;
    logic [31:0] b_pc, b_instr;
    logic [3:0]  b_ts;
    logic [2:0]  b_level;
    logic [1:0]  b_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    cv32e40x_trace_fifo #(.NUM_PORTS(2), .DEPTH(4), .TS_W(4), .CNT_W(2), .OVERWRITE(1'b0)) dut_a (
        .clk_i(clk), .rst_i(rst), .trace_en_i(trace_en), .flush_i(flush),
        .ret_valid_i(ret_valid), .ret_pc_i(ret_pc), .ret_instr_i(ret_instr),
        .out_valid_o(a_valid), .out_ready_i(out_ready), .out_pc_o(a_pc), .out_instr_o(a_instr),
        .out_ts_o(a_ts), .out_drop_o(a_drop), .level_o(a_level), .full_o(a_full),
        .empty_o(a_empty), .drop_cnt_o(a_cnt)
    );

    cv32e40x_trace_fifo #(.NUM_PORTS(2), .DEPTH(4), .TS_W(4), .CNT_W(2), .OVERWRITE(1'b1)) dut_b (
        .clk_i(clk), .rst_i(rst), .trace_en_i(trace_en), .flush_i(flush),
        .ret_valid_i(ret_valid), .ret_pc_i(ret_pc), .ret_instr_i(ret_instr),
        .out_valid_o(b_valid), .out_ready_i(out_ready), .out_pc_o(b_pc), .out_instr_o(b_instr),
        .out_ts_o(b_ts), .out_drop_o(b_drop), .level_o(b_level), .full_o(b_full),
        .empty_o(b_empty), .drop_cnt_o(b_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [31:0] pc);
        ret_valid = 2'b01;
        ret_pc    = {32'h0, pc};
        ret_instr = {32'h0, 32'h00000013};
        step();
        ret_valid = 2'b00;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total++; if (a_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", a_valid); else passed++;
        total++; if (a_pc !== 32'h0 || a_instr !== 32'h0) $display("FAIL reset_data: pc %h instr %h want 0", a_pc, a_instr); else passed++;
        total++; if (a_ts !== 4'h0 || a_drop !== 1'b0) $display("FAIL reset_ts_drop: ts %0d drop %b want 0 0", a_ts, a_drop); else passed++;
        total++; if (a_level !== 3'd0 || a_full !== 1'b0 || a_empty !== 1'b1) $display("FAIL reset_level: level %0d full %b empty %b want 0 0 1", a_level, a_full, a_empty); else passed++;
        total++; if (a_cnt !== 2'd0 || b_cnt !== 2'd0) $display("FAIL reset_cnt: a %0d b %0d want 0", a_cnt, b_cnt); else passed++;
    endtask

    task automatic test_single_push();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        push1(32'h100);
        total++; if (a_valid !== 1'b1 || a_pc !== 32'h100) $display("FAIL single_head: valid %b pc %h want 1 00000100", a_valid, a_pc); else passed++;
        total++; if (a_instr !== 32'h13) $display("FAIL single_instr: got %h want 00000013", a_instr); else passed++;
        total++; if (a_ts !== 4'd5 || a_drop !== 1'b0) $display("FAIL single_ts: ts %0d drop %b want 5 0", a_ts, a_drop); else passed++;
        total++; if (a_level !== 3'd1 || a_empty !== 1'b0) $display("FAIL single_level: level %0d empty %b want 1 0", a_level, a_empty); else passed++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++; if (a_valid !== 1'b0 || a_level !== 3'd0 || a_empty !== 1'b1) $display("FAIL single_pop: valid %b level %0d empty %b want 0 0 1", a_valid, a_level, a_empty); else passed++;
    endtask

    task automatic test_dual_order();
        do_flush();
        ret_valid = 2'b11;
        ret_pc    = {32'h204, 32'h200};
        ret_instr = {32'hAAAA0002, 32'hAAAA0001};
        step();
        ret_valid = 2'b00;
        total++; if (a_level !== 3'd2 || a_pc !== 32'h200 || a_ts !== 4'd0) $display("FAIL dual_first: level %0d pc %h ts %0d want 2 00000200 0", a_level, a_pc, a_ts); else passed++;
        total++; if (a_instr !== 32'hAAAA0001) $display("FAIL dual_first_instr: got %h want aaaa0001", a_instr); else passed++;
        out_ready = 1'b1;
        step();
        total++; if (a_pc !== 32'h204 || a_ts !== 4'd0 || a_level !== 3'd1) $display("FAIL dual_second: pc %h ts %0d level %0d want 00000204 0 1", a_pc, a_ts, a_level); else passed++;
        step();
        out_ready = 1'b0;
        total++; if (a_empty !== 1'b1) $display("FAIL dual_drained: empty %b want 1", a_empty); else passed++;
    endtask

    task automatic test_overflow();
        logic [31:0] exp_a [5];
        logic [31:0] exp_b [5];
        logic        exp_ad [5];
        logic        exp_bd [5];
        exp_a  = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h300};
        exp_b  = '{32'h2, 32'h3, 32'h4, 32'h5, 32'h300};
        exp_ad = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_bd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        do_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push1(32'(i));
        total++; if (a_level !== 3'd4 || a_full !== 1'b1 || a_cnt !== 2'd2) $display("FAIL dropnew_full: level %0d full %b cnt %0d want 4 1 2", a_level, a_full, a_cnt); else passed++;
        total++; if (b_level !== 3'd4 || b_full !== 1'b1 || b_cnt !== 2'd2) $display("FAIL overwrite_full: level %0d full %b cnt %0d want 4 1 2", b_level, b_full, b_cnt); else passed++;
        ret_valid = 2'b01;
        ret_pc    = {32'h0, 32'h300};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++; if (a_pc !== exp_a[i] || a_drop !== exp_ad[i]) $display("FAIL dropnew_drain%0d: pc %h drop %b want %h %b", i, a_pc, a_drop, exp_a[i], exp_ad[i]); else passed++;
            total++; if (b_pc !== exp_b[i] || b_drop !== exp_bd[i]) $display("FAIL overwrite_drain%0d: pc %h drop %b want %h %b", i, b_pc, b_drop, exp_b[i], exp_bd[i]); else passed++;
            step();
            ret_valid = 2'b00;
        end
        out_ready = 1'b0;
        total++; if (a_empty !== 1'b1 || b_empty !== 1'b1) $display("FAIL overflow_drained: a_empty %b b_empty %b want 1 1", a_empty, b_empty); else passed++;
        total++; if (a_cnt !== 2'd2 || b_cnt !== 2'd2) $display("FAIL overflow_cnt: a %0d b %0d want 2 2", a_cnt, b_cnt); else passed++;
    endtask

    task automatic test_full_pop_flush();
        do_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push1(32'h40 + 32'(i));
        push1(32'h45);
        total++; if (a_level !== 3'd4 || a_cnt !== 2'd1) $display("FAIL fullpop_pre: level %0d cnt %0d want 4 1", a_level, a_cnt); else passed++;
        out_ready = 1'b1;
        push1(32'h44);
        total++; if (a_level !== 3'd4 || a_cnt !== 2'd1 || a_pc !== 32'h41) $display("FAIL fullpop_a: level %0d cnt %0d pc %h want 4 1 00000041", a_level, a_cnt, a_pc); else passed++;
        total++; if (b_level !== 3'd4 || b_cnt !== 2'd1) $display("FAIL fullpop_b: level %0d cnt %0d want 4 1", b_level, b_cnt); else passed++;
        flush = 1'b1;
        push1(32'h46);
        flush     = 1'b0;
        out_ready = 1'b0;
        total++; if (a_level !== 3'd0 || a_empty !== 1'b1 || a_valid !== 1'b0) $display("FAIL flush_level: level %0d empty %b valid %b want 0 1 0", a_level, a_empty, a_valid); else passed++;
        total++; if (a_cnt !== 2'd0 || b_cnt !== 2'd0) $display("FAIL flush_cnt: a %0d b %0d want 0 0", a_cnt, b_cnt); else passed++;
        push1(32'h50);
        total++; if (a_pc !== 32'h50 || a_ts !== 4'd0 || a_drop !== 1'b0) $display("FAIL flush_ts: pc %h ts %0d drop %b want 00000050 0 0", a_pc, a_ts, a_drop); else passed++;
    endtask

    task automatic test_saturation();
        do_flush();
        out_ready = 1'b0;
        ret_pc    = {32'h1004, 32'h1000};
        ret_valid = 2'b01; step();
        ret_valid = 2'b11; step();
        ret_valid = 2'b11; step();
        total++; if (a_level !== 3'd4 || a_cnt !== 2'd1 || b_cnt !== 2'd1) $display("FAIL partial_drop: level %0d a_cnt %0d b_cnt %0d want 4 1 1", a_level, a_cnt, b_cnt); else passed++;
        ret_valid = 2'b11; step();
        total++; if (a_cnt !== 2'd3) $display("FAIL sat_reach: cnt %0d want 3", a_cnt); else passed++;
        ret_valid = 2'b01; step();
        ret_valid = 2'b01; step();
        ret_valid = 2'b00;
        total++; if (a_cnt !== 2'd3 || b_cnt !== 2'd3) $display("FAIL sat_hold: a %0d b %0d want 3 3", a_cnt, b_cnt); else passed++;
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (a_level !== 3'd0 || a_valid !== 1'b0 || b_level !== 3'd0) $display("FAIL midreset_level: a %0d valid %b b %0d want 0 0 0", a_level, a_valid, b_level); else passed++;
        total++; if (a_cnt !== 2'd0 || b_cnt !== 2'd0) $display("FAIL midreset_cnt: a %0d b %0d want 0 0", a_cnt, b_cnt); else passed++;
    endtask

    task automatic test_ts_wrap();
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) step();
        push1(32'h600);
        total++; if (a_pc !== 32'h600 || a_ts !== 4'd1) $display("FAIL ts_wrap: pc %h ts %0d want 00000600 1", a_pc, a_ts); else passed++;
        trace_en  = 1'b0;
        ret_valid = 2'b01;
        ret_pc    = {32'h0, 32'h700};
        for (int i = 0; i < 3; i++) step();
        total++; if (a_level !== 3'd1 || b_level !== 3'd1) $display("FAIL disabled_push: a %0d b %0d want 1 1", a_level, b_level); else passed++;
        trace_en = 1'b1;
        push1(32'h800);
        total++; if (a_level !== 3'd2) $display("FAIL enabled_push: level %0d want 2", a_level); else passed++;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++; if (a_pc !== 32'h800 || a_ts !== 4'd2) $display("FAIL ts_frozen: pc %h ts %0d want 00000800 2", a_pc, a_ts); else passed++;
    endtask

    initial begin
        rst       = 1'b1;
        trace_en  = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        ret_valid = 2'b00;
        ret_pc    = '0;
        ret_instr = '0;
        test_reset();
        test_single_push();
        test_dual_order();
        test_overflow();
        test_full_pop_flush();
        test_saturation();
        test_reset_mid();
        test_ts_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
